// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the fetch/data memory-port arbiter.
// Carries the fetch requester, the data requester and the shared downstream
// memory port. The arbiter sits on the "master" side: it serves both
// requesters and masters the single downstream memory port. The "slave"
// side is the environment (core requesters plus memory controller).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_stall;
  logic [DATA_W-1:0] i_instr;

  // Data-access requester
  logic              d_en;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wd;
  logic              d_stall;
  logic [DATA_W-1:0] d_rd;

  // Shared downstream memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_stall;
  logic [DATA_W-1:0] mem_rd;

  modport master (
    input  i_req, i_addr,
    output i_stall, i_instr,
    input  d_en, d_we, d_addr, d_wd,
    output d_stall, d_rd,
    output mem_en, mem_we, mem_addr, mem_wd,
    input  mem_stall, mem_rd
  );

  modport slave (
    output i_req, i_addr,
    input  i_stall, i_instr,
    output d_en, d_we, d_addr, d_wd,
    input  d_stall, d_rd,
    input  mem_en, mem_we, mem_addr, mem_wd,
    output mem_stall, mem_rd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the
// instruction-fetch and data-access requesters (stall-style handshake).
// The grant is a registered FSM state; request fields pass through to the
// memory combinationally while granted. A grant is held until its
// transaction completes (mem_en=1 and mem_stall=0). The most recent winner
// is remembered in last_r so that a tie goes to the other requester.
// conflict_cnt counts edges where both requesters were asking, for
// performance debugging.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_port_arbiter_if.master   bus,
  output logic [CNT_W-1:0]     conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t            state_r;
  state_t            state_s;
  logic              last_r;
  logic              last_s;
  logic [CNT_W-1:0]  conflict_cnt_r;

  logic              mem_en_s;
  logic              we_raw_s;
  logic [ADDR_W-1:0] addr_raw_s;
  logic [DATA_W-1:0] wd_raw_s;
  logic              i_stall_s;
  logic              d_stall_s;
  logic              both_req_s;

  assign both_req_s = bus.i_req & bus.d_en;

  // Downstream port and requester stalls decoded from the current grant.
  always_comb begin
    mem_en_s   = 1'b0;
    we_raw_s   = 1'b0;
    addr_raw_s = {ADDR_W{1'b0}};
    wd_raw_s   = {DATA_W{1'b0}};
    i_stall_s  = bus.i_req;
    d_stall_s  = bus.d_en;
    case (state_r)
      IDLE: begin
        mem_en_s  = 1'b0;
        i_stall_s = bus.i_req;
        d_stall_s = bus.d_en;
      end
      GNT_I: begin
        // Fetches never write; the stall is qualified by the request so a
        // dropped request never sees a stall.
        mem_en_s   = bus.i_req;
        we_raw_s   = 1'b0;
        addr_raw_s = bus.i_addr;
        wd_raw_s   = {DATA_W{1'b0}};
        i_stall_s  = bus.i_req & bus.mem_stall;
        d_stall_s  = bus.d_en;
      end
      GNT_D: begin
        mem_en_s   = bus.d_en;
        we_raw_s   = bus.d_we;
        addr_raw_s = bus.d_addr;
        wd_raw_s   = bus.d_wd;
        d_stall_s  = bus.d_en & bus.mem_stall;
        i_stall_s  = bus.i_req;
      end
      default: begin
        mem_en_s  = 1'b0;
        i_stall_s = bus.i_req;
        d_stall_s = bus.d_en;
      end
    endcase
  end

  // Next grant and round-robin pointer.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (both_req_s) begin
          state_s = (last_r == LAST_D) ? GNT_I : GNT_D;
        end else if (bus.i_req) begin
          state_s = GNT_I;
        end else if (bus.d_en) begin
          state_s = GNT_D;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_I: begin
        if (!bus.i_req) begin
          // Request withdrawn without completion: pointer untouched.
          state_s = bus.d_en ? GNT_D : IDLE;
        end else if (bus.mem_stall) begin
          state_s = GNT_I;
        end else begin
          // Completion: the other side goes next if waiting, otherwise the
          // grant is kept so a back-to-back fetch needs no idle bubble.
          last_s  = LAST_I;
          state_s = bus.d_en ? GNT_D : GNT_I;
        end
      end
      GNT_D: begin
        if (!bus.d_en) begin
          state_s = bus.i_req ? GNT_I : IDLE;
        end else if (bus.mem_stall) begin
          state_s = GNT_D;
        end else begin
          last_s  = LAST_D;
          state_s = bus.i_req ? GNT_I : GNT_D;
        end
      end
      default: begin
        state_s = IDLE;
        last_s  = last_r;
      end
    endcase
  end

  // Grant state and last-winner register; reset makes fetch win the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      last_r  <= LAST_D;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Conflict counter: one count per edge with both requests high, wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (both_req_s) begin
      conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  // Idle downstream fields are forced to zero so the controller sees a
  // clean bus whenever mem_en is low.
  assign bus.mem_en   = mem_en_s;
  assign bus.mem_we   = mem_en_s & we_raw_s;
  assign bus.mem_addr = mem_en_s ? addr_raw_s : {ADDR_W{1'b0}};
  assign bus.mem_wd   = mem_en_s ? wd_raw_s : {DATA_W{1'b0}};
  assign bus.i_stall  = i_stall_s;
  assign bus.d_stall  = d_stall_s;

  // Read data is shared; each requester qualifies it with its own stall.
  assign bus.i_instr  = bus.mem_rd;
  assign bus.d_rd     = bus.mem_rd;

  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle-level checks plus a scoreboard
// of expected downstream transactions, popped on every memory completion.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CW-1:0] conflict_cnt;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus.master),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t sb[$];
  txn_t mon_t;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [AW-1:0] a, input logic we,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    txn_t t;
    t.is_d = is_d; t.addr = a; t.we = we; t.wd = wd; t.rd = rd;
    sb.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_en = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wd = 32'h0;
    bus.mem_stall = 1'b0; bus.mem_rd = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 64'(bus.mem_en), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Scoreboard: every downstream completion must match the next expected transaction.
  always @(negedge clk) begin
    if (rstn && bus.mem_en && !bus.mem_stall) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_t = sb.pop_front();
        check("grant", {62'd0, bus.i_req && !bus.i_stall, bus.d_en && !bus.d_stall},
              mon_t.is_d ? 64'd1 : 64'd2);
        check("mem_addr", 64'(bus.mem_addr), 64'(mon_t.addr));
        check("mem_we", 64'(bus.mem_we), 64'(mon_t.we));
        check("mem_wd", 64'(bus.mem_wd), 64'(mon_t.wd));
        if (!mon_t.we)
          check("rdata", 64'(mon_t.is_d ? bus.d_rd : bus.i_instr), 64'(mon_t.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // Single fetch from reset: two-cycle latency.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h40; bus.mem_rd = 32'hDEADBEEF;
    push(1'b0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF);
    smp();
    check("t1_c0_i_stall", 64'(bus.i_stall), 64'd1);
    check("t1_c0_mem_en", 64'(bus.mem_en), 64'd0);
    cyc(); smp();
    check("t1_c1_mem_en", 64'(bus.mem_en), 64'd1);
    check("t1_c1_mem_addr", 64'(bus.mem_addr), 64'h40);
    check("t1_c1_i_stall", 64'(bus.i_stall), 64'd0);
    check("t1_c1_i_instr", 64'(bus.i_instr), 64'hDEADBEEF);
    cyc(); bus.i_req = 1'b0; smp();
    check("t1_drop_mem_en", 64'(bus.mem_en), 64'd0);
    check("t1_drop_addr", 64'(bus.mem_addr), 64'd0);
    cyc(); cyc();

    // Both requesting from reset: I, D, I, D.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_en = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.mem_rd = 32'h1234;
    push(1'b0, 32'h10, 1'b0, 32'h0, 32'h1234);
    push(1'b1, 32'h20, 1'b0, 32'h0, 32'h1234);
    push(1'b0, 32'h10, 1'b0, 32'h0, 32'h1234);
    push(1'b1, 32'h20, 1'b0, 32'h0, 32'h1234);
    smp();
    check("t2_c0_i_stall", 64'(bus.i_stall), 64'd1);
    check("t2_c0_d_stall", 64'(bus.d_stall), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(); smp();
      check("t2_i_stall", 64'(bus.i_stall), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("t2_d_stall", 64'(bus.d_stall), (k % 2 == 1) ? 64'd1 : 64'd0);
    end
    cyc(); bus.i_req = 1'b0; bus.d_en = 1'b0; smp();
    check("t2_cnt", 64'(conflict_cnt), 64'd5);
    cyc(); cyc();

    // Stalled data write with a waiting fetch, then the fetch is granted.
    do_reset();
    bus.d_en = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wd = 32'h5;
    bus.mem_stall = 1'b1; bus.mem_rd = 32'hCAFE0044;
    push(1'b1, 32'h100, 1'b1, 32'h5, 32'h0);
    push(1'b0, 32'h44, 1'b0, 32'h0, 32'hCAFE0044);
    smp();
    check("t3_c0_d_stall", 64'(bus.d_stall), 64'd1);
    check("t3_c0_mem_en", 64'(bus.mem_en), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) begin
        bus.i_req = 1'b1; bus.i_addr = 32'h44;
      end
      bus.mem_stall = (k == 4) ? 1'b0 : 1'b1;
      smp();
      check("t3_mem_addr", 64'(bus.mem_addr), 64'h100);
      check("t3_mem_we", 64'(bus.mem_we), 64'd1);
      check("t3_mem_wd", 64'(bus.mem_wd), 64'h5);
      check("t3_d_stall", 64'(bus.d_stall), (k < 4) ? 64'd1 : 64'd0);
      check("t3_i_stall", 64'(bus.i_stall), 64'd1);
    end
    cyc(); bus.d_en = 1'b0; bus.d_we = 1'b0; smp();
    check("t3_gnt_i_mem_en", 64'(bus.mem_en), 64'd1);
    check("t3_gnt_i_addr", 64'(bus.mem_addr), 64'h44);
    check("t3_gnt_i_stall", 64'(bus.i_stall), 64'd0);
    cyc(); bus.i_req = 1'b0;
    cyc(); cyc();

    // Five back-to-back data reads: one completion per cycle.
    do_reset();
    bus.d_en = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.mem_rd = 32'hD0000000;
    push(1'b1, 32'h200, 1'b0, 32'h0, 32'hD0000000);
    smp();
    check("t4_c0_d_stall", 64'(bus.d_stall), 64'd1);
    check("t4_c0_mem_en", 64'(bus.mem_en), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k > 0) begin
        bus.d_addr = 32'h200 + 32'(4 * k);
        bus.mem_rd = 32'hD0000000 + 32'(k);
        push(1'b1, bus.d_addr, 1'b0, 32'h0, bus.mem_rd);
      end
      smp();
      check("t4_d_stall", 64'(bus.d_stall), 64'd0);
      check("t4_mem_en", 64'(bus.mem_en), 64'd1);
    end
    cyc(); bus.d_en = 1'b0; smp();
    check("t4_drop_mem_en", 64'(bus.mem_en), 64'd0);
    cyc(); cyc();

    // Reset in the middle of a stalled fetch.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h80; bus.mem_stall = 1'b1;
    cyc();
    bus.d_en = 1'b1; bus.d_addr = 32'h24;
    smp();
    check("t5_gnt_mem_en", 64'(bus.mem_en), 64'd1);
    check("t5_gnt_i_stall", 64'(bus.i_stall), 64'd1);
    check("t5_gnt_d_stall", 64'(bus.d_stall), 64'd1);
    cyc();
    check("t5_cnt_pre", 64'(conflict_cnt), 64'd1);
    rstn = 1'b0;
    #1;
    check("t5_rst_mem_en", 64'(bus.mem_en), 64'd0);
    check("t5_rst_cnt", 64'(conflict_cnt), 64'd0);
    check("t5_rst_i_stall", 64'(bus.i_stall), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1; bus.mem_stall = 1'b0; bus.mem_rd = 32'h5A5A;
    push(1'b0, 32'h80, 1'b0, 32'h0, 32'h5A5A);
    push(1'b1, 32'h24, 1'b0, 32'h0, 32'h5A5A);
    smp();
    check("t5_c0_mem_en", 64'(bus.mem_en), 64'd0);
    cyc(); smp();
    check("t5_i_first", 64'(bus.i_stall), 64'd0);
    cyc(); smp();
    check("t5_d_second", 64'(bus.d_stall), 64'd0);
    cyc(); bus.i_req = 1'b0; bus.d_en = 1'b0;
    cyc(); cyc();

    // Conflict counter wrap (4-bit counter).
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h8; bus.d_en = 1'b1; bus.d_addr = 32'hC;
    bus.mem_stall = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      cyc();
      if (n >= 14) begin
        smp();
        check("t6_cnt", 64'(conflict_cnt), 64'(n % 16));
      end
    end
    do_reset();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
